// File: rtl/div_unit_if.sv
// div_unit_if: request/result bundle between the execute stage (master) and div_unit (slave).
// Handshake: master raises start with operands and holds it until ready is seen. ready then stays high until start drops. cancel aborts in any state.
interface div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             cancel;
   logic             signed_op;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             ready;

   modport master (
      output start, cancel, signed_op, dividend, divisor,
      input  quotient, remainder, busy, ready
   );

   modport slave (
      input  start, cancel, signed_op, dividend, divisor,
      output quotient, remainder, busy, ready
   );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider (DIV/DIVU) with registered quotient/remainder.
// Define DIV_ZERO_DETECT_EN to route zero divisors through the short DIVZERO path.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst,
   div_unit_if.slave  bus,
   output logic [1:0] o_dbg_state
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DIVZERO = 2'd1,
      S_ON      = 2'd2,
      S_END     = 2'd3
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [2*WIDTH:0] r_acc;
   logic [WIDTH-1:0] r_dvs;
   logic [CW-1:0]    r_cnt;
   logic             r_neg_q;
   logic             r_neg_r;
   logic [WIDTH-1:0] r_fin_q;
   logic [WIDTH-1:0] r_fin_r;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_busy;
   logic             r_ready;
`ifdef DIV_ZERO_DETECT_EN
   logic [WIDTH-1:0] r_dvd_orig;
`endif

   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_hi;
   logic [WIDTH+1:0] w_trial;
   logic             w_trial_neg;
   logic [WIDTH:0]   w_rem;
   logic [WIDTH-1:0] w_q_mag;
   logic [WIDTH-1:0] w_r_mag;
   logic             w_last;
   logic             w_unused;

   assign w_a_neg = bus.signed_op && bus.dividend[WIDTH-1];
   assign w_b_neg = bus.signed_op && bus.divisor[WIDTH-1];
   assign w_a_mag = w_a_neg ? -bus.dividend : bus.dividend;
   assign w_b_mag = w_b_neg ? -bus.divisor : bus.divisor;

   // One restoring step: the upper WIDTH+1 bits after the left shift minus the divisor magnitude.
   assign w_hi        = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_trial     = {1'b0, w_hi} - {2'b00, r_dvs};
   assign w_trial_neg = w_trial[WIDTH+1];
   assign w_rem       = w_trial_neg ? w_hi : w_trial[WIDTH:0];
   assign w_q_mag     = {r_acc[WIDTH-2:0], ~w_trial_neg};
   assign w_r_mag     = w_rem[WIDTH-1:0];
   assign w_last      = (r_cnt == CW'(WIDTH-1));
   // The partial remainder never exceeds WIDTH bits, so the top accumulator bit is never read.
   assign w_unused    = r_acc[2*WIDTH];

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (bus.cancel) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
`ifdef DIV_ZERO_DETECT_EN
                  w_next = (bus.divisor == '0) ? S_DIVZERO : S_ON;
`else
                  w_next = S_ON;
`endif
               end
            end
`ifdef DIV_ZERO_DETECT_EN
            S_DIVZERO: w_next = S_END;
`endif
            S_ON:      if (w_last) w_next = S_END;
            S_END:     if (!bus.start) w_next = S_IDLE;
            default:   w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_acc       <= '0;
         r_dvs       <= '0;
         r_cnt       <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_fin_q     <= '0;
         r_fin_r     <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_busy      <= 1'b0;
         r_ready     <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
         r_dvd_orig  <= '0;
`endif
      end else begin
         // Status lags the state by one edge, except that cancel clears it immediately.
         r_busy  <= !bus.cancel && ((r_state == S_ON) || (r_state == S_DIVZERO));
         r_ready <= !bus.cancel && (r_state == S_END);
         case (r_state)
            S_IDLE: begin
               if (bus.start && !bus.cancel) begin
                  r_acc   <= {{(WIDTH+1){1'b0}}, w_a_mag};
                  r_dvs   <= w_b_mag;
                  r_cnt   <= '0;
                  r_neg_q <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_a_neg;
`ifdef DIV_ZERO_DETECT_EN
                  r_dvd_orig <= bus.dividend;
`endif
               end
            end
`ifdef DIV_ZERO_DETECT_EN
            S_DIVZERO: begin
               r_fin_q <= '1;
               r_fin_r <= r_dvd_orig;
            end
`endif
            S_ON: begin
               r_acc <= {w_rem, r_acc[WIDTH-2:0], ~w_trial_neg};
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_fin_q <= r_neg_q ? -w_q_mag : w_q_mag;
                  r_fin_r <= r_neg_r ? -w_r_mag : w_r_mag;
               end
            end
            S_END: begin
               if (!bus.cancel && !r_ready) begin
                  r_quotient  <= r_fin_q;
                  r_remainder <= r_fin_r;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.quotient  = r_quotient;
   assign bus.remainder = r_remainder;
   assign bus.busy      = r_busy;
   assign bus.ready     = r_ready;
   assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized self-checking bench for div_unit (WIDTH=32 and WIDTH=8 instances).
// Expected results come from plain integer division in ref_div.
module tb_div_unit;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg32;
   logic [1:0] dbg8;

   div_unit_if #(.WIDTH(32)) bus32 ();
   div_unit_if #(.WIDTH(8))  bus8 ();

   div_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32), .o_dbg_state(dbg32));
   div_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8),  .o_dbg_state(dbg8));

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] exp_q[$];
   logic [31:0] last_q;
   logic [31:0] last_r;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Returns {quotient, remainder}, each masked to n bits and zero-extended to 32.
   function automatic logic [63:0] ref_div(input int n, input bit sgn,
                                           input logic [63:0] a, input logic [63:0] b);
      longint      sa;
      longint      sb;
      logic [63:0] q;
      logic [63:0] r;
      logic [63:0] mask;
      mask = (64'd1 << n) - 64'd1;
      if (b == 64'd0) begin
         q = mask;
         r = a;
      end else if (sgn) begin
         sa = $signed(a << (64 - n)) >>> (64 - n);
         sb = $signed(b << (64 - n)) >>> (64 - n);
         q  = 64'(sa / sb);
         r  = 64'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
      q = q & mask;
      r = r & mask;
      return {q[31:0], r[31:0]};
   endfunction

   // ---------------- drivers ----------------
   task automatic run32(input string tag, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input bit chk_res, input int exp_lat);
      int          lat;
      int          busy_cnt;
      logic [63:0] exp;
      lat      = 0;
      busy_cnt = 0;
      exp      = '0;
      if (chk_res) exp_q.push_back(ref_div(32, sgn, 64'(a), 64'(b)));
      bus32.signed_op = sgn;
      bus32.dividend  = a;
      bus32.divisor   = b;
      bus32.start     = 1'b1;
      @(posedge clk); #1;
      // Operand changes after the start edge must not affect the result.
      bus32.dividend  = $urandom;
      bus32.divisor   = $urandom;
      bus32.signed_op = 1'($urandom_range(0, 1));
      while (!bus32.ready && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (bus32.busy) busy_cnt++;
      end
      check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
      check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
      if (chk_res) begin
         exp = exp_q.pop_front();
         check({tag, ".q"}, 64'(bus32.quotient), 64'(exp[63:32]));
         check({tag, ".r"}, 64'(bus32.remainder), 64'(exp[31:0]));
         last_q = exp[63:32];
         last_r = exp[31:0];
      end
      bus32.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check({tag, ".ready_drop"}, 64'(bus32.ready), 64'd0);
      if (chk_res) check({tag, ".hold_q"}, 64'(bus32.quotient), 64'(exp[63:32]));
   endtask

   task automatic run8(input string tag, input bit sgn, input logic [7:0] a, input logic [7:0] b);
      int          lat;
      logic [63:0] exp;
      lat = 0;
      exp = ref_div(8, sgn, 64'(a), 64'(b));
      bus8.signed_op = sgn;
      bus8.dividend  = a;
      bus8.divisor   = b;
      bus8.start     = 1'b1;
      @(posedge clk); #1;
      bus8.dividend = 8'($urandom);
      bus8.divisor  = 8'($urandom);
      while (!bus8.ready && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, ".lat"}, 64'(lat), 64'd9);
      check({tag, ".q"}, 64'(bus8.quotient), 64'(exp[63:32]));
      check({tag, ".r"}, 64'(bus8.remainder), 64'(exp[31:0]));
      bus8.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic        saw_ready;
      logic [31:0] a;
      logic [31:0] b;
      int          mode;
      bit          sgn;

      rst = 1'b0;
      bus32.start = 1'b0; bus32.cancel = 1'b0; bus32.signed_op = 1'b0;
      bus32.dividend = '0; bus32.divisor = '0;
      bus8.start = 1'b0; bus8.cancel = 1'b0; bus8.signed_op = 1'b0;
      bus8.dividend = '0; bus8.divisor = '0;
      last_q = '0;
      last_r = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset.q", 64'(bus32.quotient), 64'd0);
      check("reset.r", 64'(bus32.remainder), 64'd0);
      check("reset.busy", 64'(bus32.busy), 64'd0);
      check("reset.ready", 64'(bus32.ready), 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      run32("u100_7", 1'b0, 32'd100, 32'd7, 1'b1, 33);
      run32("s-100_7", 1'b1, -32'sd100, 32'd7, 1'b1, 33);
      run32("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33);
      run32("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1, 33);
      run32("s7_-2", 1'b1, 32'd7, -32'sd2, 1'b1, 33);

      // cancel beats start in IDLE
      bus32.start = 1'b1; bus32.cancel = 1'b1;
      bus32.dividend = 32'd50; bus32.divisor = 32'd5;
      @(posedge clk); #1;
      bus32.start = 1'b0; bus32.cancel = 1'b0;
      @(posedge clk); #1;
      check("cancel_idle.busy", 64'(bus32.busy), 64'd0);

      // cancel mid-operation: status clears on the next edge, outputs hold
      bus32.signed_op = 1'b0; bus32.dividend = 32'd1000; bus32.divisor = 32'd3;
      bus32.start = 1'b1;
      @(posedge clk); #1;
      repeat (10) begin @(posedge clk); #1; end
      bus32.cancel = 1'b1;
      bus32.start  = 1'b0;
      @(posedge clk); #1;
      check("cancel.busy", 64'(bus32.busy), 64'd0);
      check("cancel.ready", 64'(bus32.ready), 64'd0);
      check("cancel.hold_q", 64'(bus32.quotient), 64'(last_q));
      check("cancel.hold_r", 64'(bus32.remainder), 64'(last_r));
      bus32.cancel = 1'b0;
      saw_ready = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         saw_ready = saw_ready | bus32.ready;
      end
      check("cancel.no_ready", 64'(saw_ready), 64'd0);
      run32("u9_3", 1'b0, 32'd9, 32'd3, 1'b1, 33);

      // reset mid-division
      bus32.signed_op = 1'b0; bus32.dividend = 32'd5000; bus32.divisor = 32'd7;
      bus32.start = 1'b1;
      @(posedge clk); #1;
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_mid.q", 64'(bus32.quotient), 64'd0);
      check("rst_mid.r", 64'(bus32.remainder), 64'd0);
      check("rst_mid.busy", 64'(bus32.busy), 64'd0);
      check("rst_mid.ready", 64'(bus32.ready), 64'd0);
      rst = 1'b1;
      bus32.start = 1'b0;
      last_q = '0;
      last_r = '0;
      @(posedge clk); #1;

      // randomized operands with biased divisor classes
      for (int i = 0; i < 30; i++) begin
         mode = $urandom_range(0, 3);
         sgn  = 1'($urandom_range(0, 1));
         a    = $urandom;
         b    = $urandom;
         case (mode)
            0: b = 32'($urandom_range(1, 15));
            2: b = 32'hFFFF_FFFF;
            3: a = 32'h8000_0000;
            default: ;
         endcase
         if (b == 32'd0) b = 32'd1;
         run32($sformatf("rand%0d", i), sgn, a, b, 1'b1, 33);
      end

`ifdef DIV_ZERO_DETECT_EN
      run32("divzero_u", 1'b0, 32'h1234, 32'd0, 1'b1, 2);
      run32("divzero_s", 1'b1, 32'h1234, 32'd0, 1'b1, 2);
`else
      run32("divzero", 1'b0, 32'h1234, 32'd0, 1'b0, 33);
`endif

      run8("w8_255_16", 1'b0, 8'd255, 8'd16);
      run8("w8_s_min_m1", 1'b1, 8'h80, 8'hFF);
      for (int i = 0; i < 6; i++) begin
         logic [7:0] a8;
         logic [7:0] b8;
         a8 = 8'($urandom);
         b8 = 8'($urandom_range(1, 255));
         run8($sformatf("w8_rand%0d", i), 1'($urandom_range(0, 1)), a8, b8);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
